// File: rtl/morse_code_decoder.sv
// Morse receive path: synchronizes and debounces a keyed input, times marks and
// gaps, and emits one ASCII byte per character (plus a space per word gap).
module morse_code_decoder #(
  parameter int unsigned UNIT_CYCLES     = 600000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [7:0] char_data,
  output logic       char_strb,
  output logic       decode_err
);

  localparam int unsigned CW = $clog2(8 * UNIT_CYCLES + 1);
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(8 * UNIT_CYCLES);
  localparam logic [CW-1:0] CHAR_GAP = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] WORD_GAP = CW'(5 * UNIT_CYCLES);
  localparam logic [CW-1:0] DAH_MIN  = CW'(2 * UNIT_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, GAP} state_t;

  state_t          state, state_nxt;
  logic            sync1, sync2;
  logic            lvl;
  logic [DW-1:0]   db_cnt;
  logic [CW-1:0]   cnt;
  logic [5:0]      pat, pat_nxt;
  logic [2:0]      elem_cnt, elem_cnt_nxt;
  logic            ovf, ovf_nxt;
  logic            word_pend, word_pend_nxt;
  logic            chg, rise, fall;
  logic            emit, emit_err;
  logic [7:0]      emit_char;
  logic            elem_dah;
  logic [7:0]      lut_char;
  logic            lut_err;

  // chg marks the cycle in which lvl is about to flip, so cnt still holds the
  // length of the interval that is ending (length = cnt + 1).
  assign chg  = (sync2 != lvl) && (db_cnt == DB_LAST);
  assign rise = chg && !lvl;
  assign fall = chg && lvl;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      lvl    <= 1'b0;
      db_cnt <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= morse_in;
      sync2 <= sync1;
      if (sync2 != lvl) begin
        if (db_cnt == DB_LAST) begin
          lvl    <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
      if (chg)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    lut_char = 8'h3F;
    lut_err  = 1'b1;
    if (!ovf) begin
      lut_err = 1'b0;
      case ({elem_cnt, pat})
        {3'd2, 6'b000010}: lut_char = 8'h41; // A
        {3'd4, 6'b000001}: lut_char = 8'h42; // B
        {3'd4, 6'b000101}: lut_char = 8'h43; // C
        {3'd3, 6'b000001}: lut_char = 8'h44; // D
        {3'd1, 6'b000000}: lut_char = 8'h45; // E
        {3'd4, 6'b000100}: lut_char = 8'h46; // F
        {3'd3, 6'b000011}: lut_char = 8'h47; // G
        {3'd4, 6'b000000}: lut_char = 8'h48; // H
        {3'd2, 6'b000000}: lut_char = 8'h49; // I
        {3'd4, 6'b001110}: lut_char = 8'h4A; // J
        {3'd3, 6'b000101}: lut_char = 8'h4B; // K
        {3'd4, 6'b000010}: lut_char = 8'h4C; // L
        {3'd2, 6'b000011}: lut_char = 8'h4D; // M
        {3'd2, 6'b000001}: lut_char = 8'h4E; // N
        {3'd3, 6'b000111}: lut_char = 8'h4F; // O
        {3'd4, 6'b000110}: lut_char = 8'h50; // P
        {3'd4, 6'b001011}: lut_char = 8'h51; // Q
        {3'd3, 6'b000010}: lut_char = 8'h52; // R
        {3'd3, 6'b000000}: lut_char = 8'h53; // S
        {3'd1, 6'b000001}: lut_char = 8'h54; // T
        {3'd3, 6'b000100}: lut_char = 8'h55; // U
        {3'd4, 6'b001000}: lut_char = 8'h56; // V
        {3'd3, 6'b000110}: lut_char = 8'h57; // W
        {3'd4, 6'b001001}: lut_char = 8'h58; // X
        {3'd4, 6'b001101}: lut_char = 8'h59; // Y
        {3'd4, 6'b000011}: lut_char = 8'h5A; // Z
        {3'd5, 6'b011111}: lut_char = 8'h30; // 0
        {3'd5, 6'b011110}: lut_char = 8'h31; // 1
        {3'd5, 6'b011100}: lut_char = 8'h32; // 2
        {3'd5, 6'b011000}: lut_char = 8'h33; // 3
        {3'd5, 6'b010000}: lut_char = 8'h34; // 4
        {3'd5, 6'b000000}: lut_char = 8'h35; // 5
        {3'd5, 6'b000001}: lut_char = 8'h36; // 6
        {3'd5, 6'b000011}: lut_char = 8'h37; // 7
        {3'd5, 6'b000111}: lut_char = 8'h38; // 8
        {3'd5, 6'b001111}: lut_char = 8'h39; // 9
        default: begin
          lut_char = 8'h3F;
          lut_err  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    pat_nxt       = pat;
    elem_cnt_nxt  = elem_cnt;
    ovf_nxt       = ovf;
    word_pend_nxt = word_pend;
    emit          = 1'b0;
    emit_char     = 8'h00;
    emit_err      = 1'b0;
    elem_dah      = (cnt >= DAH_MIN);
    case (state)
      IDLE: begin
        if (word_pend && cnt == WORD_GAP) begin
          emit          = 1'b1;
          emit_char     = 8'h20;
          word_pend_nxt = 1'b0;
        end
        if (rise)
          state_nxt = MARK;
      end
      MARK: begin
        if (fall) begin
          if (elem_cnt < 3'd6) begin
            pat_nxt      = pat | (6'(elem_dah) << elem_cnt);
            elem_cnt_nxt = elem_cnt + 3'd1;
          end else begin
            ovf_nxt = 1'b1;
          end
          state_nxt = GAP;
        end
      end
      GAP: begin
        // A rise on the threshold cycle starts a fresh character after emission.
        if (cnt == CHAR_GAP) begin
          emit          = 1'b1;
          emit_char     = lut_char;
          emit_err      = lut_err;
          pat_nxt       = '0;
          elem_cnt_nxt  = '0;
          ovf_nxt       = 1'b0;
          word_pend_nxt = 1'b1;
          state_nxt     = rise ? MARK : IDLE;
        end else if (rise) begin
          state_nxt = MARK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pat        <= '0;
      elem_cnt   <= '0;
      ovf        <= 1'b0;
      word_pend  <= 1'b0;
      char_data  <= 8'h00;
      char_strb  <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      pat        <= pat_nxt;
      elem_cnt   <= elem_cnt_nxt;
      ovf        <= ovf_nxt;
      word_pend  <= word_pend_nxt;
      char_strb  <= emit;
      decode_err <= emit && emit_err;
      if (emit)
        char_data <= emit_char;
    end
  end

endmodule

// File: doc/morse_code_decoder.md
# morse_code_decoder

Receive-side counterpart of the Morse encoder. Samples a single keyed Morse input, debounces it, and classifies marks as dit or dah from their duration. It detects inter-character and inter-word gaps and emits one ASCII character per decoded symbol with a one-cycle strobe. It sits beside the encoder/tone path and produces a byte stream in the same strobe style as the PS/2 receive path.

## Interface
Parameters:
- UNIT_CYCLES, 600000: clk cycles per Morse time unit (one dit length); must be ≥ 4.
- DEBOUNCE_CYCLES, 1000: consecutive stable synchronized samples required before a level change is accepted; must be ≥ 1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- morse_in  input  1  keyed Morse signal, asynchronous, high = mark (key down).
- char_data  output  8  decoded ASCII character; held until the next strobe.
- char_strb  output  1  one-cycle pulse; char_data is valid in the same cycle.
- decode_err  output  1  one-cycle pulse coincident with char_strb when the pattern is unmapped or overflowed.

## Operation
- Input conditioning: 2-flop synchronizer, then debouncer. The debounced level (lvl) changes only after DEBOUNCE_CYCLES identical synchronized samples differing from the current lvl.
- Duration counter cnt: cleared to 0 on every lvl edge, +1 per cycle otherwise, saturating at 8·UNIT_CYCLES. Width: ceil(log2(8·UNIT_CYCLES+1)).
- Symbol register: pat[5:0], where bit i is element i in order of arrival (0 = dit, 1 = dah). Also elem_cnt[2:0] and an ovf flag.
- FSM states:
  - IDLE: lvl low, no elements pending. lvl rise → MARK.
  - MARK: lvl fall with captured length L = cnt+1:
    - L < 2·UNIT_CYCLES → dit; otherwise dah.
    - If elem_cnt < 6, append the element and increment elem_cnt; else set ovf.
    - Go to GAP.
  - GAP:
    - lvl rise before cnt reaches 2·UNIT_CYCLES → MARK, same character.
    - cnt reaches 2·UNIT_CYCLES → emit the character, clear pat/elem_cnt/ovf, set word_pend, go to IDLE.
- Word gap: in IDLE with word_pend=1, cnt reaching 5·UNIT_CYCLES emits 0x20 and clears word_pend. At most one space per gap; no space is emitted before the first character after reset.
- Lookup (combinational from pat, elem_cnt):
  - International Morse A–Z maps to 0x41–0x5A.
  - 0–9 (5 elements) maps to 0x30–0x39.
  - Any other pattern, or ovf=1, maps to 0x3F '?' with decode_err=1.
- Marks are never truncated. A mark longer than 8·UNIT_CYCLES is still a dah because cnt saturates.

## Timing
- Reset values: char_data=0x00, char_strb=0, decode_err=0, FSM=IDLE, lvl=0, cnt=0, pat=0, elem_cnt=0, ovf=0, word_pend=0, synchronizer and debounce counters=0.
- Input latency: a morse_in change reaches lvl 2 + DEBOUNCE_CYCLES cycles later. Mark and gap lengths are measured on lvl, so durations are preserved.
- Character strobe: char_strb, char_data, and decode_err are registered and assert the cycle after cnt == 2·UNIT_CYCLES in GAP. Space strobe is the cycle after cnt == 5·UNIT_CYCLES in IDLE.
- Simultaneous events:
  - An lvl rise in the same cycle cnt hits the gap threshold: emission wins. The new mark starts a fresh character.
  - Emission and the next lvl fall can never coincide.
- char_strb never asserts on consecutive cycles. Minimum spacing is 2·UNIT_CYCLES.
- Reset mid-character discards partial pat with no strobe. A reset asserted in the same cycle as a pending strobe suppresses it.
- Pulses shorter than DEBOUNCE_CYCLES are invisible to the FSM.

## Test plan
All cases use UNIT_CYCLES=8, DEBOUNCE_CYCLES=2.
- Reset: hold rst 3 cycles with morse_in toggling → all outputs 0, no strobe for 100 cycles after release with morse_in=0.
- Letter 'A': mark 8, gap 8, mark 24, then low 30 → exactly one char_strb with char_data=0x41, decode_err=0, 16+2 cycles after the last fall.
- Word gap: 'E' (mark 8), then low 60 → strobe 0x45, then exactly one strobe 0x20. A further 200 low cycles produce no strobe.
- Digit and overflow:
  - Five dits (8 on / 8 off), then low 30 → 0x35.
  - Seven dits, then low 30 → 0x3F with decode_err=1.
  - Pattern ..-- → 0x3F with decode_err=1.
- Glitch and reset: a 1-cycle high pulse produces no strobe. Send a dit, assert rst for 1 cycle during the gap, then low 30 → no strobe. A subsequent 'T' (mark 24) → 0x54.
